// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// default timeout and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The reserved size 2'b11 is always treated as misaligned.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic w_mis;
    case (size)
      SIZE_BYTE: w_mis = 1'b0;
      SIZE_HALF: w_mis = lo[0];
      SIZE_WORD: w_mis = (lo != 2'b00);
      default:   w_mis = 1'b1;
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-aligned ready/valid data-memory bus between the LSU (master) and memory (slave).
interface lsu_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane shift, load extraction
// with sign/zero extension, and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_uext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;

  assign w_shamt      = {i_addr_lo, 3'b000};
  assign w_shifted    = i_rword >> w_shamt;
  assign o_wdata      = i_wdata << w_shamt;
  assign o_misaligned = size_misaligned(i_size, i_addr_lo);

  always_comb begin
    o_be    = 4'b0000;
    o_rdata = w_shifted;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {{24{~i_uext & w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_rdata = {{16{~i_uext & w_shifted[15]}}, w_shifted[15:0]};
      end
      SIZE_WORD: begin
        o_be    = 4'b1111;
        o_rdata = w_shifted;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per core memory access, stalling the
// core until the response (or a timeout) arrives.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRd,
  input  logic        memWr,
  input  logic [1:0]  maskSel,
  input  logic        uext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  lsu_if.master       bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [1:0]        r_addr_lo;
  logic [1:0]        r_size;
  logic              r_uext;
  logic              r_we;
  logic [31:0]       r_bus_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_req;
  logic              w_stall;
  logic              w_fault;
  logic              w_timeout;
  logic [1:0]        w_sel_lo;
  logic [1:0]        w_sel_size;
  logic              w_sel_uext;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;
  logic              w_misaligned;

  assign w_req     = memRd | memWr;
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // In IDLE the lane logic sees the live request; afterwards the latched access.
  assign w_sel_lo   = (r_state == ST_IDLE) ? addr[1:0] : r_addr_lo;
  assign w_sel_size = (r_state == ST_IDLE) ? maskSel   : r_size;
  assign w_sel_uext = (r_state == ST_IDLE) ? uext      : r_uext;

  lsu_align u_align (
    .i_size       (w_sel_size),
    .i_addr_lo    (w_sel_lo),
    .i_uext       (w_sel_uext),
    .i_wdata      (wdata),
    .i_rword      (bus.bus_resp_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_load),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_fault   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_misaligned) begin
          w_fault = 1'b1;
        end else if (w_req) begin
          w_stall = 1'b1;
          w_next  = ST_REQ;
        end else begin
          w_next  = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (bus.bus_req_ready && bus.bus_resp_valid) begin
          w_next = ST_DONE;
        end else if (bus.bus_req_ready) begin
          w_next = ST_WAIT;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (bus.bus_resp_valid) begin
          w_next = ST_DONE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_fault   = 1'b1;
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Payload, counter and result registers; rdata is non-zero only while in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr_lo  <= 2'b00;
      r_size     <= 2'b00;
      r_uext     <= 1'b0;
      r_we       <= 1'b0;
      r_bus_addr <= 32'h0000_0000;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0000_0000;
      r_rdata    <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == ST_WAIT && w_next == ST_WAIT) ? w_cnt_inc : '0;
      if (r_state == ST_IDLE && w_next == ST_REQ) begin
        r_addr_lo  <= addr[1:0];
        r_size     <= maskSel;
        r_uext     <= uext;
        r_we       <= memWr;
        r_bus_addr <= {addr[31:2], 2'b00};
        r_be       <= w_be;
        r_wdata    <= w_wdata;
      end
      if (w_next == ST_DONE) begin
        r_rdata <= (r_we || w_timeout) ? 32'h0000_0000 : w_load;
      end else begin
        r_rdata <= 32'h0000_0000;
      end
    end
  end

  assign stall             = w_stall & ~reset;
  assign fault             = w_fault & ~reset;
  assign rdata             = r_rdata;
  assign bus.bus_req_valid = (r_state == ST_REQ);
  assign bus.bus_addr      = r_bus_addr;
  assign bus.bus_we        = r_we;
  assign bus.bus_be        = r_be;
  assign bus.bus_wdata     = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// compared against a byte-lane reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRd;
  logic        memWr;
  logic [1:0]  maskSel;
  logic        uext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  lsu_if bus_if ();

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .memRd   (memRd),
    .memWr   (memWr),
    .maskSel (maskSel),
    .uext    (uext),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .stall   (stall),
    .fault   (fault),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int m_nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int n = m_nbytes(sz);
    if (n == 0) return 1'b1;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be;
    int lo = int'(a[1:0]);
    int n  = m_nbytes(sz);
    for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
    return be;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                         input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v = 32'h0;
    logic [31:0] ones = 32'hFFFF_FFFF;
    int lo = int'(a[1:0]);
    int n  = m_nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(lo+i) +: 8];
    if (n < 4 && !u && v[8*n-1]) v = v | (ones << (8*n));
    return v;
  endfunction

  // Runs one access from an IDLE negedge; rsp_dly 0 = response with ready,
  // k = response in the k-th WAIT cycle, > TO = no response.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int rdy_dly, input int rsp_dly,
                            input logic late_resp);
    logic        mis;
    logic [31:0] exp_rd;
    int          stalls;
    int          exp_stalls;
    memRd = rd; memWr = wr; maskSel = sz; uext = u; addr = a; wdata = wd;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = $urandom;
    #1;
    mis = m_misaligned(sz, a);
    chk("idle_fault", fault, mis);
    chk("idle_stall", stall, !mis);
    chk("idle_req_valid", bus_if.bus_req_valid, 0);
    if (mis) begin
      @(negedge clk);
      memRd = 1'b0; memWr = 1'b0;
      #1;
      chk("mis_no_req", bus_if.bus_req_valid, 0);
      chk("mis_fault_once", fault, 0);
      return;
    end
    stalls = 1;
    @(negedge clk);
    for (int c = 0; c <= rdy_dly; c++) begin
      if (c == rdy_dly) begin
        bus_if.bus_req_ready  = 1'b1;
        bus_if.bus_resp_valid = (rsp_dly == 0);
        bus_if.bus_resp_rdata = (rsp_dly == 0) ? rw : $urandom;
      end
      #1;
      chk("req_valid", bus_if.bus_req_valid, 1);
      chk("req_addr", bus_if.bus_addr, (a / 4) * 4);
      chk("req_be", bus_if.bus_be, m_be(sz, a));
      chk("req_we", bus_if.bus_we, wr);
      chk("req_wdata", bus_if.bus_wdata, wd << (8 * int'(a[1:0])));
      chk("req_fault", fault, 0);
      stalls += int'(stall);
      @(negedge clk);
    end
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    if (rsp_dly > 0) begin
      for (int k = 1; k <= TO; k++) begin
        bus_if.bus_resp_valid = (k == rsp_dly);
        bus_if.bus_resp_rdata = (k == rsp_dly) ? rw : $urandom;
        #1;
        chk("wait_req_valid", bus_if.bus_req_valid, 0);
        chk("wait_fault", fault, (k == TO) && (rsp_dly > TO));
        stalls += int'(stall);
        @(negedge clk);
        if (k == rsp_dly) break;
      end
      bus_if.bus_resp_valid = 1'b0;
    end
    exp_rd = (wr || rsp_dly > TO) ? 32'h0 : m_load(sz, u, a, rw);
    if (late_resp) begin
      bus_if.bus_resp_valid = 1'b1;
      bus_if.bus_resp_rdata = rw;
    end
    #1;
    exp_stalls = 2 + rdy_dly + ((rsp_dly > TO) ? TO : rsp_dly);
    chk("done_stall", stall, 0);
    chk("done_fault", fault, 0);
    chk("done_rdata", rdata, exp_rd);
    chk("stall_cycles", stalls, exp_stalls);
    @(negedge clk);
    memRd = 1'b0; memWr = 1'b0;
    #1;
    chk("after_rdata", rdata, 0);
    chk("after_stall", stall, 0);
    chk("after_req_valid", bus_if.bus_req_valid, 0);
    bus_if.bus_resp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_valid"}, bus_if.bus_req_valid, 0);
    chk({tag, "_addr"}, bus_if.bus_addr, 0);
    chk({tag, "_we"}, bus_if.bus_we, 0);
    chk({tag, "_be"}, bus_if.bus_be, 0);
    chk({tag, "_wdata"}, bus_if.bus_wdata, 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          op;
    reset = 1'b1; memRd = 1'b0; memWr = 1'b0; maskSel = 2'b00; uext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_resp_valid = 1'b0; bus_if.bus_resp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0);
    run_access(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    run_access(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    run_access(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h22, 32'h0000_ABCD, 32'h0, 4, 1, 1'b0);
    run_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1, 1'b0);
    run_access(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0);
    run_access(1'b1, 1'b0, 2'b11,     1'b0, 32'h100, 32'h0, 32'h0, 0, 1, 1'b0);
    run_access(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
    run_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'h1234_5678, 1, TO + 3, 1'b1);

    // Reset while the access sits in WAIT.
    memRd = 1'b1; memWr = 1'b0; maskSel = SIZE_WORD; addr = 32'h400; uext = 1'b0;
    bus_if.bus_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.bus_req_ready = 1'b0;
    #1;
    chk("pre_reset_stall", stall, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0; memRd = 1'b0;
    @(negedge clk);
    run_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == SIZE_WORD) ra[1:0] = 2'b00;
        if (rs == SIZE_HALF) ra[0] = 1'b0;
      end
      op = $urandom_range(0, 2);
      run_access(op != 1, op != 0, rs, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
